// File: rtl/regfile_pkg.sv
// Shared sizing defaults and output-stage state encoding for the dual-read register file.
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;
  localparam int unsigned REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/regfile_entry.sv
// One register-file entry: WIDTH-bit register with async clear and write enable.
module regfile_entry #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_dual_read.sv
// Register file with one write port and two read ports sharing a one-deep,
// valid/accept handshaked output register; r0 is hard-wired to zero.
module regfile_dual_read
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic             rd_gnt,
  output logic             rd_valid,
  input  logic             rd_accept,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_hit;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  rd_state_t        state;

  assign mem[0] = '0;

  // Only in-range, non-zero addresses are writable.
  assign wr_hit = we && (waddr != '0) && (32'(waddr) < DEPTH);

  for (genvar i = 1; i < int'(DEPTH); i++) begin : g_entry
    regfile_entry #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .clr (clr),
      .en  (wr_hit && (waddr == AW'(i))),
      .d   (wdata),
      .q   (mem[i])
    );
  end

  assign rd_gnt = rd_req && (!rd_valid || rd_accept);

  // Read values as they would be after this edge's write (write-through bypass).
  always_comb begin
    cap_a = '0;
    cap_b = '0;
    if (32'(raddr_a) < DEPTH) cap_a = mem[raddr_a];
    if (32'(raddr_b) < DEPTH) cap_b = mem[raddr_b];
    if (wr_hit && (waddr == raddr_a)) cap_a = wdata;
    if (wr_hit && (waddr == raddr_b)) cap_b = wdata;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_EMPTY;
      rd_valid <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (rd_gnt) begin
            state    <= ST_FULL;
            rd_valid <= 1'b1;
            rdata_a  <= cap_a;
            rdata_b  <= cap_b;
          end
        end
        ST_FULL: begin
          if (rd_gnt) begin
            rdata_a <= cap_a;
            rdata_b <= cap_b;
          end else if (rd_accept) begin
            state    <= ST_EMPTY;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dual_read.sv
// Directed plus random bench for regfile_dual_read against an array-based reference model.
module tb_regfile_dual_read;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rd_req;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        rd_gnt;
  logic        rd_valid;
  logic        rd_accept;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;

  always #5 clk = ~clk;

  regfile_dual_read dut (
    .clk       (clk),
    .clr       (clr),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rd_req    (rd_req),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_accept (rd_accept),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'd0;
    if (w && wa == addr) return wd;
    return m_mem[addr];
  endfunction

  task automatic model_clear();
    foreach (m_mem[i]) m_mem[i] = 32'd0;
    m_valid = 1'b0;
    m_a = 32'd0;
    m_b = 32'd0;
  endtask

  // One clock cycle: drive, check grant mid-cycle, advance model at the edge, check outputs.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rq, input logic [4:0] a, input logic [4:0] b,
                      input logic acc);
    logic g;
    we = w; waddr = wa; wdata = wd;
    rd_req = rq; raddr_a = a; raddr_b = b; rd_accept = acc;
    g = rq && (!m_valid || acc);
    #3;
    chk("rd_gnt", 32'(rd_gnt), 32'(g));
    @(posedge clk);
    if (g) begin
      m_a = model_read(a, w, wa, wd);
      m_b = model_read(b, w, wa, wd);
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (w && wa != 5'd0) m_mem[wa] = wd;
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rdata_a", rdata_a, m_a);
    chk("rdata_b", rdata_b, m_b);
  endtask

  // Pulse clr across one edge with a write and request present; both must be dropped.
  task automatic pulse_reset();
    clr = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE0001;
    rd_req = 1'b1; raddr_a = 5'd9; raddr_b = 5'd9; rd_accept = 1'b1;
    #1;
    model_clear();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    @(posedge clk);
    #3;
    clr = 1'b0;
    we = 1'b0; rd_req = 1'b0; rd_accept = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(rd_valid), 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; raddr_a = '0; raddr_b = '0; rd_accept = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    pulse_reset();

    // Write r5, then read a=5, b=0.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
    chk("r5_a", rdata_a, 32'hDEADBEEF);
    chk("r0_b", rdata_b, 32'd0);
    // Write to r0 is ignored.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);
    chk("r0_a", rdata_a, 32'd0);

    // Bypass: write r7 in the grant cycle.
    step(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b1);
    chk("bypass_a", rdata_a, 32'h12345678);
    chk("bypass_b", rdata_b, 32'h12345678);

    // Stall: FULL holding r5, three cycles without accept while r5 is rewritten.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7, 1'b1);
    held = rdata_a;
    chk("stall_pre", held, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 5'd5, 1'b0);
      chk("stall_hold", rdata_a, 32'hDEADBEEF);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b1);
    chk("stall_release", rdata_a, 32'h1);

    // Streaming: preload r1..r8 then eight back-to-back grants.
    for (int i = 1; i <= 8; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(9 - i), 1'b1);
      chk("stream_valid", 32'(rd_valid), 32'd1);
      chk("stream_a", rdata_a, 32'(i));
    end

    // Drain: accept with no new request empties the stage, data held.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_a", rdata_a, 32'd8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 3) != 0));
    end

    // Reset while FULL, then every entry reads zero.
    step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 1'b1);
    chk("pre_rst_full", 32'(rd_valid), 32'd1);
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(2 * i), 5'(2 * i + 1), 1'b1);
      chk("zero_a", rdata_a, 32'd0);
      chk("zero_b", rdata_b, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
